// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU/next-PC encodings, destination
// selects and the ID/EX control word.
package mips_pkg;

    localparam logic [4:0] ALUOP_ADD  = 5'b00001;
    localparam logic [4:0] ALUOP_ADDU = 5'b00010;
    localparam logic [4:0] ALUOP_SUB  = 5'b00011;
    localparam logic [4:0] ALUOP_AND  = 5'b00100;
    localparam logic [4:0] ALUOP_OR   = 5'b00101;
    localparam logic [4:0] ALUOP_SLT  = 5'b00110;
    localparam logic [4:0] ALUOP_LUI  = 5'b00111;
    localparam logic [4:0] ALUOP_BEQ  = 5'b01000;

    localparam logic [2:0] NPC_SEQ = 3'd0;
    localparam logic [2:0] NPC_BEQ = 3'd1;
    localparam logic [2:0] NPC_J   = 3'd2;
    localparam logic [2:0] NPC_JR  = 3'd3;
    localparam logic [2:0] NPC_JAL = 3'd4;

    localparam logic [1:0] DST_RT  = 2'b00;
    localparam logic [1:0] DST_RD  = 2'b01;
    localparam logic [1:0] DST_R31 = 2'b10;

    localparam logic [4:0] REG_RA = 5'd31;

    // Decoder control word carried through ID/EX.
    typedef struct packed {
        logic [4:0] aluop;
        logic       reg_write;
        logic       s_b;
        logic       mem_write;
        logic [1:0] s_data_write;
        logic [2:0] npcop;
        logic       memtoreg;
    } ctrl_t;

    // Map the destination select onto a register number; the reserved
    // encoding falls back to $zero so it can never write anything.
    function automatic logic [4:0] resolve_dst(input logic [1:0] sel,
                                               input logic [4:0] rt,
                                               input logic [4:0] rd);
        case (sel)
            DST_RT:  return rt;
            DST_RD:  return rd;
            DST_R31: return REG_RA;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the load sitting in EX and the
// instruction currently in ID. Purely combinational.
module hazard_detect
    import mips_pkg::*;
(
    input  logic       i_ex_valid,
    input  logic       i_ex_memtoreg,
    input  logic       i_ex_reg_write,
    input  logic [4:0] i_ex_wr_num,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_flush,
    output logic       o_load_use,
    output logic       o_stall
);

    logic w_src_match;

    // rt is compared even for instructions that do not read it; the extra
    // stall is cheaper than decoding which operands are really used.
    always_comb begin
        w_src_match = (i_ex_wr_num == i_id_rs) | (i_ex_wr_num == i_id_rt);
        o_load_use  = i_ex_valid & i_ex_memtoreg & i_ex_reg_write &
                      (i_ex_wr_num != 5'd0) & w_src_match;
        // A taken branch redirects fetch anyway, so freezing IF/ID is pointless.
        o_stall     = o_load_use & ~i_flush;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches control and operands, resolves the
// destination register and inserts bubbles on load-use or flush.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold_i,
    input  logic          flush_i,
    input  logic [4:0]    id_aluop,
    input  logic          id_reg_write,
    input  logic          id_s_b,
    input  logic [1:0]    id_s_num_write,
    input  logic          id_mem_write,
    input  logic [1:0]    id_s_data_write,
    input  logic [2:0]    id_npcop,
    input  logic          id_memtoreg,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_ext_imm,
    input  logic [DW-1:0] id_pc4,
    output logic [4:0]    ex_aluop,
    output logic          ex_reg_write,
    output logic          ex_s_b,
    output logic          ex_mem_write,
    output logic [1:0]    ex_s_data_write,
    output logic [2:0]    ex_npcop,
    output logic          ex_memtoreg,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [4:0]    ex_wr_num,
    output logic [DW-1:0] ex_rs_data,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_ext_imm,
    output logic [DW-1:0] ex_pc4,
    output logic          ex_valid,
    output logic          stall_o,
    output logic [CW-1:0] bubble_cnt
);

    ctrl_t         r_ctrl;
    logic [4:0]    r_rs;
    logic [4:0]    r_rt;
    logic [4:0]    r_wr_num;
    logic [DW-1:0] r_rs_data;
    logic [DW-1:0] r_rt_data;
    logic [DW-1:0] r_ext_imm;
    logic [DW-1:0] r_pc4;
    logic          r_valid;
    logic [CW-1:0] r_bubble_cnt;

    logic [4:0]    w_dst;
    logic          w_load_use;
    logic          w_bubble;
    ctrl_t         w_id_ctrl;

    hazard_detect u_hazard (
        .i_ex_valid     (r_valid),
        .i_ex_memtoreg  (r_ctrl.memtoreg),
        .i_ex_reg_write (r_ctrl.reg_write),
        .i_ex_wr_num    (r_wr_num),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_flush        (flush_i),
        .o_load_use     (w_load_use),
        .o_stall        (stall_o)
    );

    // Resolve destination and pack the incoming control word; a write to
    // $zero is dropped here so it never reaches writeback or forwarding.
    always_comb begin
        w_dst                  = resolve_dst(id_s_num_write, id_rt, id_rd);
        w_id_ctrl.aluop        = id_aluop;
        w_id_ctrl.reg_write    = id_reg_write & (w_dst != 5'd0);
        w_id_ctrl.s_b          = id_s_b;
        w_id_ctrl.mem_write    = id_mem_write;
        w_id_ctrl.s_data_write = id_s_data_write;
        w_id_ctrl.npcop        = id_npcop;
        w_id_ctrl.memtoreg     = id_memtoreg;
        w_bubble               = flush_i | w_load_use;
    end

    // Pipeline register: hold > flush/load-use bubble > capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl    <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_wr_num  <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_ext_imm <= '0;
            r_pc4     <= '0;
            r_valid   <= 1'b0;
        end else if (!hold_i) begin
            if (w_bubble) begin
                r_ctrl    <= '0;
                r_rs      <= '0;
                r_rt      <= '0;
                r_wr_num  <= '0;
                r_rs_data <= '0;
                r_rt_data <= '0;
                r_ext_imm <= '0;
                r_pc4     <= '0;
                r_valid   <= 1'b0;
            end else begin
                r_ctrl    <= w_id_ctrl;
                r_rs      <= id_rs;
                r_rt      <= id_rt;
                r_wr_num  <= w_dst;
                r_rs_data <= id_rs_data;
                r_rt_data <= id_rt_data;
                r_ext_imm <= id_ext_imm;
                r_pc4     <= id_pc4;
                r_valid   <= 1'b1;
            end
        end
    end

    // Saturating count of bubbles inserted by flush or load-use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_bubble_cnt <= '0;
        else if (!hold_i && w_bubble && (r_bubble_cnt != {CW{1'b1}}))
            r_bubble_cnt <= r_bubble_cnt + CW'(1);
    end

    assign ex_aluop        = r_ctrl.aluop;
    assign ex_reg_write    = r_ctrl.reg_write;
    assign ex_s_b          = r_ctrl.s_b;
    assign ex_mem_write    = r_ctrl.mem_write;
    assign ex_s_data_write = r_ctrl.s_data_write;
    assign ex_npcop        = r_ctrl.npcop;
    assign ex_memtoreg     = r_ctrl.memtoreg;
    assign ex_rs           = r_rs;
    assign ex_rt           = r_rt;
    assign ex_wr_num       = r_wr_num;
    assign ex_rs_data      = r_rs_data;
    assign ex_rt_data      = r_rt_data;
    assign ex_ext_imm      = r_ext_imm;
    assign ex_pc4          = r_pc4;
    assign ex_valid        = r_valid;
    assign bubble_cnt      = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (CW = 4 for saturation).
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk, rst, hold_i, flush_i;
    logic [4:0]    id_aluop;
    logic          id_reg_write, id_s_b, id_mem_write, id_memtoreg;
    logic [1:0]    id_s_num_write, id_s_data_write;
    logic [2:0]    id_npcop;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rs_data, id_rt_data, id_ext_imm, id_pc4;
    logic [4:0]    ex_aluop;
    logic          ex_reg_write, ex_s_b, ex_mem_write, ex_memtoreg;
    logic [1:0]    ex_s_data_write;
    logic [2:0]    ex_npcop;
    logic [4:0]    ex_rs, ex_rt, ex_wr_num;
    logic [DW-1:0] ex_rs_data, ex_rt_data, ex_ext_imm, ex_pc4;
    logic          ex_valid, stall_o;
    logic [CW-1:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i),
        .id_aluop(id_aluop), .id_reg_write(id_reg_write), .id_s_b(id_s_b),
        .id_s_num_write(id_s_num_write), .id_mem_write(id_mem_write),
        .id_s_data_write(id_s_data_write), .id_npcop(id_npcop),
        .id_memtoreg(id_memtoreg), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_ext_imm(id_ext_imm), .id_pc4(id_pc4),
        .ex_aluop(ex_aluop), .ex_reg_write(ex_reg_write), .ex_s_b(ex_s_b),
        .ex_mem_write(ex_mem_write), .ex_s_data_write(ex_s_data_write),
        .ex_npcop(ex_npcop), .ex_memtoreg(ex_memtoreg), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_wr_num(ex_wr_num), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_ext_imm(ex_ext_imm), .ex_pc4(ex_pc4),
        .ex_valid(ex_valid), .stall_o(stall_o), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one decoded instruction; operand data is tagged by register number.
    task automatic drive(input logic [4:0] aluop, input logic rw, input logic sb,
                         input logic mw, input logic [1:0] sdw, input logic [2:0] npc,
                         input logic m2r, input logic [1:0] snw,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_aluop = aluop; id_reg_write = rw; id_s_b = sb; id_mem_write = mw;
        id_s_data_write = sdw; id_npcop = npc; id_memtoreg = m2r;
        id_s_num_write = snw; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = 32'h1000_0000 | {27'd0, rs};
        id_rt_data = 32'h2000_0000 | {27'd0, rt};
        id_ext_imm = 32'h0000_0040;
        id_pc4     = 32'h0040_0004;
    endtask

    task automatic nop();
        drive(5'd0, 1'b0, 1'b0, 1'b0, 2'd0, NPC_SEQ, 1'b0, DST_RT, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic lw(input logic [4:0] base, input logic [4:0] dst);
        drive(ALUOP_ADD, 1'b1, 1'b1, 1'b0, 2'd1, NPC_SEQ, 1'b1, DST_RT, base, dst, 5'd0);
    endtask

    task automatic do_reset();
        hold_i = 1'b0; flush_i = 1'b0;
        nop();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        nop();
        rst = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
        #1 rst = 1'b1;
        tick();
        checks++;
        if ({ex_valid, ex_reg_write, ex_memtoreg, ex_mem_write, ex_aluop, ex_npcop, ex_wr_num, ex_rs, ex_rt} !== '0) begin
            errors++; $display("FAIL reset_ctrl: valid=%b rw=%b wr=%0d aluop=%b", ex_valid, ex_reg_write, ex_wr_num, ex_aluop);
        end
        checks++;
        if ({ex_rs_data, ex_rt_data, ex_ext_imm, ex_pc4} !== '0) begin
            errors++; $display("FAIL reset_data: rs_data=%h pc4=%h expected 0", ex_rs_data, ex_pc4);
        end
        checks++;
        if (bubble_cnt !== 4'd0 || stall_o !== 1'b0) begin
            errors++; $display("FAIL reset_cnt: cnt=%0d stall=%b expected 0/0", bubble_cnt, stall_o);
        end
        rst = 1'b0;
        lw(5'd1, 5'd5);
        tick();
        drive(ALUOP_ADD, 1'b1, 1'b0, 1'b0, 2'd0, NPC_SEQ, 1'b0, DST_RD, 5'd5, 5'd2, 5'd4);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++; $display("FAIL reset_prestall: stall=%b expected 1", stall_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0 || ex_memtoreg !== 1'b0 || ex_valid !== 1'b0 || ex_rs_data !== '0) begin
            errors++; $display("FAIL reset_midstall: stall=%b m2r=%b valid=%b expected 0", stall_o, ex_memtoreg, ex_valid);
        end
        tick();
        rst = 1'b0;
        drive(ALUOP_ADDU, 1'b1, 1'b0, 1'b0, 2'd0, NPC_SEQ, 1'b0, DST_RD, 5'd1, 5'd2, 5'd3);
        tick();
        checks++;
        if (ex_wr_num !== 5'd3 || ex_reg_write !== 1'b1 || ex_aluop !== 5'b00010 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL reset_addu: wr=%0d rw=%b aluop=%b valid=%b expected 3/1/00010/1", ex_wr_num, ex_reg_write, ex_aluop, ex_valid);
        end
        checks++;
        if (ex_rs_data !== 32'h1000_0001 || ex_rt_data !== 32'h2000_0002 || bubble_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_addu_data: rs_data=%h rt_data=%h cnt=%0d", ex_rs_data, ex_rt_data, bubble_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        lw(5'd1, 5'd5);
        tick();
        drive(ALUOP_ADD, 1'b1, 1'b0, 1'b0, 2'd0, NPC_SEQ, 1'b0, DST_RD, 5'd5, 5'd2, 5'd4);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++; $display("FAIL lu_stall: stall=%b expected 1", stall_o);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_wr_num !== 5'd0 || ex_reg_write !== 1'b0 || ex_rs !== 5'd0 || bubble_cnt !== 4'd1 || stall_o !== 1'b0) begin
            errors++; $display("FAIL lu_bubble: valid=%b wr=%0d rw=%b rs=%0d cnt=%0d stall=%b expected 0/0/0/0/1/0",
                               ex_valid, ex_wr_num, ex_reg_write, ex_rs, bubble_cnt, stall_o);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_wr_num !== 5'd4 || ex_rs !== 5'd5 || bubble_cnt !== 4'd1) begin
            errors++; $display("FAIL lu_capture: valid=%b wr=%0d rs=%0d cnt=%0d expected 1/4/5/1", ex_valid, ex_wr_num, ex_rs, bubble_cnt);
        end
        lw(5'd1, 5'd5);
        tick();
        drive(ALUOP_ADD, 1'b1, 1'b0, 1'b0, 2'd0, NPC_SEQ, 1'b0, DST_RD, 5'd6, 5'd7, 5'd4);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++; $display("FAIL lu_nomatch: stall=%b expected 0", stall_o);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || bubble_cnt !== 4'd1) begin
            errors++; $display("FAIL lu_nomatch_cap: valid=%b cnt=%0d expected 1/1", ex_valid, bubble_cnt);
        end
        lw(5'd1, 5'd5);
        tick();
        drive(ALUOP_OR, 1'b1, 1'b0, 1'b0, 2'd0, NPC_SEQ, 1'b0, DST_RD, 5'd1, 5'd5, 5'd4);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++; $display("FAIL lu_rt: stall=%b expected 1", stall_o);
        end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        lw(5'd1, 5'd5);
        tick();
        drive(ALUOP_ADD, 1'b1, 1'b0, 1'b0, 2'd0, NPC_SEQ, 1'b0, DST_RD, 5'd5, 5'd2, 5'd4);
        flush_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++; $display("FAIL flush_stall: stall=%b expected 0", stall_o);
        end
        tick();
        flush_i = 1'b0;
        checks++;
        if (ex_valid !== 1'b0 || ex_memtoreg !== 1'b0 || bubble_cnt !== 4'd1) begin
            errors++; $display("FAIL flush_bubble: valid=%b m2r=%b cnt=%0d expected 0/0/1", ex_valid, ex_memtoreg, bubble_cnt);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_wr_num !== 5'd4 || bubble_cnt !== 4'd1) begin
            errors++; $display("FAIL flush_next: valid=%b wr=%0d cnt=%0d expected 1/4/1", ex_valid, ex_wr_num, bubble_cnt);
        end
    endtask

    task automatic test_hold();
        do_reset();
        drive(ALUOP_ADDU, 1'b1, 1'b0, 1'b0, 2'd0, NPC_SEQ, 1'b0, DST_RD, 5'd1, 5'd2, 5'd3);
        tick();
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(ALUOP_SUB, 1'b1, 1'b1, 1'b1, 2'd2, NPC_J, 1'b0, DST_RD, 5'd8, 5'd9, 5'd10 + 5'(i));
            id_pc4 = 32'h0000_1000 + 32'(i);
            flush_i = (i == 1);
            tick();
        end
        checks++;
        if (ex_wr_num !== 5'd3 || ex_aluop !== ALUOP_ADDU || ex_valid !== 1'b1 || ex_pc4 !== 32'h0040_0004 || ex_rs !== 5'd1) begin
            errors++; $display("FAIL hold_keep: wr=%0d aluop=%b valid=%b pc4=%h rs=%0d", ex_wr_num, ex_aluop, ex_valid, ex_pc4, ex_rs);
        end
        checks++;
        if (bubble_cnt !== 4'd0) begin
            errors++; $display("FAIL hold_cnt: cnt=%0d expected 0", bubble_cnt);
        end
        flush_i = 1'b1;
        tick();
        checks++;
        if (bubble_cnt !== 4'd0 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL hold_flush: cnt=%0d valid=%b expected 0/1", bubble_cnt, ex_valid);
        end
        hold_i = 1'b0;
        tick();
        flush_i = 1'b0;
        checks++;
        if (ex_valid !== 1'b0 || bubble_cnt !== 4'd1) begin
            errors++; $display("FAIL hold_release: valid=%b cnt=%0d expected 0/1", ex_valid, bubble_cnt);
        end
    endtask

    task automatic test_dest();
        do_reset();
        drive(ALUOP_ADD, 1'b1, 1'b0, 1'b0, 2'd2, NPC_JAL, 1'b0, DST_R31, 5'd0, 5'd0, 5'd0);
        tick();
        checks++;
        if (ex_wr_num !== 5'd31 || ex_reg_write !== 1'b1 || ex_npcop !== NPC_JAL) begin
            errors++; $display("FAIL dst_jal: wr=%0d rw=%b npc=%0d expected 31/1/4", ex_wr_num, ex_reg_write, ex_npcop);
        end
        drive(ALUOP_ADD, 1'b1, 1'b0, 1'b0, 2'd0, NPC_SEQ, 1'b0, DST_RD, 5'd1, 5'd2, 5'd0);
        tick();
        checks++;
        if (ex_wr_num !== 5'd0 || ex_reg_write !== 1'b0 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL dst_rd0: wr=%0d rw=%b valid=%b expected 0/0/1", ex_wr_num, ex_reg_write, ex_valid);
        end
        drive(ALUOP_ADD, 1'b1, 1'b0, 1'b0, 2'd0, NPC_SEQ, 1'b0, 2'b11, 5'd1, 5'd2, 5'd7);
        tick();
        checks++;
        if (ex_wr_num !== 5'd0 || ex_reg_write !== 1'b0) begin
            errors++; $display("FAIL dst_rsvd: wr=%0d rw=%b expected 0/0", ex_wr_num, ex_reg_write);
        end
        lw(5'd1, 5'd0);
        tick();
        drive(ALUOP_ADD, 1'b1, 1'b0, 1'b0, 2'd0, NPC_SEQ, 1'b0, DST_RD, 5'd0, 5'd0, 5'd4);
        #1;
        checks++;
        if (stall_o !== 1'b0 || ex_memtoreg !== 1'b1 || ex_reg_write !== 1'b0) begin
            errors++; $display("FAIL dst_lw0: stall=%b m2r=%b rw=%b expected 0/1/0", stall_o, ex_memtoreg, ex_reg_write);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        lw(5'd1, 5'd5);
        tick();
        lw(5'd8, 5'd6);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++; $display("FAIL b2b_indep: stall=%b expected 0", stall_o);
        end
        tick();
        lw(5'd6, 5'd7);
        #1;
        checks++;
        if (stall_o !== 1'b1 || ex_wr_num !== 5'd6) begin
            errors++; $display("FAIL b2b_dep: stall=%b wr=%0d expected 1/6", stall_o, ex_wr_num);
        end
        tick();
        tick();
        checks++;
        if (ex_wr_num !== 5'd7 || ex_valid !== 1'b1 || bubble_cnt !== 4'd1) begin
            errors++; $display("FAIL b2b_cap: wr=%0d valid=%b cnt=%0d expected 7/1/1", ex_wr_num, ex_valid, bubble_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        flush_i = 1'b1;
        repeat (14) tick();
        checks++;
        if (bubble_cnt !== 4'd14) begin
            errors++; $display("FAIL sat_14: cnt=%0d expected 14", bubble_cnt);
        end
        tick();
        checks++;
        if (bubble_cnt !== 4'd15) begin
            errors++; $display("FAIL sat_15: cnt=%0d expected 15", bubble_cnt);
        end
        repeat (3) tick();
        checks++;
        if (bubble_cnt !== 4'd15) begin
            errors++; $display("FAIL sat_hold: cnt=%0d expected 15", bubble_cnt);
        end
        flush_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_flush();
        test_hold();
        test_dest();
        test_back_to_back();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
